// File: rtl/midi_msg_parser.sv
// midi_msg_parser: MIDI channel-voice parser with running status, channel mask and SysEx skipping
module midi_msg_parser #(
    parameter bit RUNNING_STATUS = 1'b1,
    parameter bit HONOR_RESET    = 1'b1,
    parameter bit VEL0_IS_OFF    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ch_mask,
    input  logic [7:0]  data,
    input  logic        dv,
    output logic        ev_valid,
    output logic [2:0]  ev_type,
    output logic [3:0]  ev_chan,
    output logic [6:0]  ev_d0,
    output logic [6:0]  ev_d1,
    output logic        sys_reset,
    output logic [1:0]  state
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA1 = 2'd1;
    localparam logic [1:0] S_DATA2 = 2'd2;
    localparam logic [1:0] S_SYSEX = 2'd3;

    logic [1:0] r_state;
    logic       r_rs_valid;
    logic [2:0] r_rs_type;
    logic [3:0] r_rs_chan;
    logic       r_en;
    logic [6:0] r_d0;
    logic       r_ev_valid;
    logic [2:0] r_ev_type;
    logic [3:0] r_ev_chan;
    logic [6:0] r_ev_d0;
    logic [6:0] r_ev_d1;
    logic       r_sys_reset;

    logic       w_data;
    logic       w_start;
    logic       w_fin2;
    logic       w_en1;
    logic       w_one;
    logic       w_emit;
    logic       w_chstat;
    logic       w_rst_byte;
    logic [6:0] w_d0;
    logic [6:0] w_d1;
    logic [2:0] w_type;

    // status nibble 0x8..0xE minus 8 is exactly the event type code
    always_comb begin
        w_data     = !data[7];
        w_start    = w_data && (r_state == S_DATA1 || (r_state == S_IDLE && RUNNING_STATUS && r_rs_valid));
        w_fin2     = w_data && r_state == S_DATA2;
        w_en1      = r_state == S_IDLE ? ch_mask[r_rs_chan] : r_en;
        w_one      = r_rs_type == 3'd4 || r_rs_type == 3'd5;
        w_emit     = (w_start && w_one && w_en1) || (w_fin2 && r_en);
        w_chstat   = data[7] && data[7:4] != 4'hF;
        w_rst_byte = HONOR_RESET && data == 8'hFF;
        w_d0       = w_start ? data[6:0] : r_d0;
        w_d1       = w_fin2 ? data[6:0] : 7'd0;
        w_type     = (VEL0_IS_OFF && r_rs_type == 3'd1 && w_d1 == 7'd0) ? 3'd0 : r_rs_type;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rs_valid  <= 1'b0;
            r_rs_type   <= 3'd0;
            r_rs_chan   <= 4'd0;
            r_en        <= 1'b0;
            r_d0        <= 7'd0;
            r_ev_valid  <= 1'b0;
            r_ev_type   <= 3'd0;
            r_ev_chan   <= 4'd0;
            r_ev_d0     <= 7'd0;
            r_ev_d1     <= 7'd0;
            r_sys_reset <= 1'b0;
        end else begin
            r_ev_valid  <= 1'b0;
            r_sys_reset <= 1'b0;
            if (dv) begin
                if (w_emit) begin
                    r_ev_valid <= 1'b1;
                    r_ev_type  <= w_type;
                    r_ev_chan  <= r_rs_chan;
                    r_ev_d0    <= w_d0;
                    r_ev_d1    <= w_d1;
                end
                if (w_start) begin
                    r_d0    <= data[6:0];
                    r_en    <= w_en1;
                    r_state <= w_one ? S_IDLE : S_DATA2;
                end else if (w_fin2) begin
                    r_state <= S_IDLE;
                end else if (w_chstat) begin
                    r_rs_valid <= 1'b1;
                    r_rs_type  <= data[6:4];
                    r_rs_chan  <= data[3:0];
                    r_en       <= ch_mask[data[3:0]];
                    r_state    <= S_DATA1;
                end else if (w_rst_byte) begin
                    r_rs_valid  <= 1'b0;
                    r_state     <= S_IDLE;
                    r_sys_reset <= 1'b1;
                end else if (data == 8'hF0) begin
                    r_rs_valid <= 1'b0;
                    r_state    <= S_SYSEX;
                end else if (data[7:3] == 5'b11110) begin
                    r_rs_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            end
        end
    end

    assign ev_valid  = r_ev_valid;
    assign ev_type   = r_ev_type;
    assign ev_chan   = r_ev_chan;
    assign ev_d0     = r_ev_d0;
    assign ev_d1     = r_ev_d1;
    assign sys_reset = r_sys_reset;
    assign state     = r_state;
endmodule

// File: tb/tb_midi_msg_parser.sv
// tb_midi_msg_parser: directed checks of decoded events, running status, filtering and resets
module tb_midi_msg_parser;
    logic        clk;
    logic        rst;
    logic [15:0] ch_mask;
    logic [7:0]  data;
    logic        dv;
    logic        ev_valid;
    logic [2:0]  ev_type;
    logic [3:0]  ev_chan;
    logic [6:0]  ev_d0;
    logic [6:0]  ev_d1;
    logic        sys_reset;
    logic [1:0]  state;
    logic [21:0] ev;
    logic [21:0] exp_ev;
    int          errors;
    int          checks;

    midi_msg_parser dut (
        .clk(clk), .rst(rst), .ch_mask(ch_mask), .data(data), .dv(dv),
        .ev_valid(ev_valid), .ev_type(ev_type), .ev_chan(ev_chan),
        .ev_d0(ev_d0), .ev_d1(ev_d1), .sys_reset(sys_reset), .state(state)
    );

    assign ev = {ev_valid, ev_type, ev_chan, ev_d0, ev_d1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // outputs are observed 1 time unit after the edge that sampled the byte
    task automatic send(input logic [7:0] b);
        data = b;
        dv = 1'b1;
        @(posedge clk);
        #1;
        dv = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dv = 1'b0;
        data = 8'h00;
        ch_mask = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ev !== 22'd0) begin errors++; $display("FAIL reset_ev got=%h exp=%h", ev, 22'd0); end
        checks++; if (sys_reset !== 1'b0) begin errors++; $display("FAIL reset_sys got=%b exp=0", sys_reset); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_running_status();
        ch_mask = 16'hFFFF;
        send(8'h93);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL rs_state1 got=%0d exp=1", state); end
        send(8'h3C);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL rs_state2 got=%0d exp=2", state); end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rs_early got=%b exp=0", ev_valid); end
        send(8'h64);
        exp_ev = {1'b1, 3'd1, 4'd3, 7'h3C, 7'h64};
        checks++; if (ev !== exp_ev) begin errors++; $display("FAIL rs_note_on got=%h exp=%h", ev, exp_ev); end
        send(8'h40);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rs_one_cycle got=%b exp=0", ev_valid); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL rs_restart got=%0d exp=2", state); end
        send(8'h00);
        exp_ev = {1'b1, 3'd0, 4'd3, 7'h40, 7'h00};
        checks++; if (ev !== exp_ev) begin errors++; $display("FAIL rs_vel0_off got=%h exp=%h", ev, exp_ev); end
        idle();
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rs_hold got=%b exp=0", ev_valid); end
        checks++; if (ev_d0 !== 7'h40) begin errors++; $display("FAIL rs_field_hold got=%h exp=40", ev_d0); end
    endtask

    task automatic test_back_to_back();
        data = 8'hB0;
        dv = 1'b1;
        @(posedge clk); #1; data = 8'hF8;
        @(posedge clk); #1;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL rt_state got=%0d exp=1", state); end
        data = 8'h07;
        @(posedge clk); #1; data = 8'hFE;
        @(posedge clk); #1;
        checks++; if (state !== 2'd2 || ev_valid !== 1'b0) begin errors++; $display("FAIL rt_mid got=%0d/%b exp=2/0", state, ev_valid); end
        data = 8'h7F;
        @(posedge clk); #1;
        exp_ev = {1'b1, 3'd3, 4'd0, 7'h07, 7'h7F};
        checks++; if (ev !== exp_ev) begin errors++; $display("FAIL rt_cc got=%h exp=%h", ev, exp_ev); end
        data = 8'hC5;
        @(posedge clk); #1;
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL prog_status got=%b exp=0", ev_valid); end
        data = 8'h10;
        @(posedge clk); #1;
        exp_ev = {1'b1, 3'd4, 4'd5, 7'h10, 7'h00};
        checks++; if (ev !== exp_ev) begin errors++; $display("FAIL prog_a got=%h exp=%h", ev, exp_ev); end
        data = 8'h11;
        @(posedge clk); #1;
        dv = 1'b0;
        exp_ev = {1'b1, 3'd4, 4'd5, 7'h11, 7'h00};
        checks++; if (ev !== exp_ev) begin errors++; $display("FAIL prog_b got=%h exp=%h", ev, exp_ev); end
    endtask

    task automatic test_filter();
        ch_mask = 16'h0001;
        send(8'h91); send(8'h40); send(8'h40);
        checks++; if (ev_valid !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL filt_drop got=%b/%0d exp=0/0", ev_valid, state); end
        send(8'h90); send(8'h41); send(8'h42);
        exp_ev = {1'b1, 3'd1, 4'd0, 7'h41, 7'h42};
        checks++; if (ev !== exp_ev) begin errors++; $display("FAIL filt_pass got=%h exp=%h", ev, exp_ev); end
        ch_mask = 16'h0000;
        send(8'h43); send(8'h44);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL filt_resample got=%b exp=0", ev_valid); end
    endtask

    task automatic test_sysex();
        ch_mask = 16'hFFFF;
        send(8'hF0);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL sx_enter got=%0d exp=3", state); end
        send(8'h7E); send(8'h10);
        checks++; if (state !== 2'd3 || ev_valid !== 1'b0) begin errors++; $display("FAIL sx_body got=%0d/%b exp=3/0", state, ev_valid); end
        send(8'hF7);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL sx_exit got=%0d exp=0", state); end
        send(8'h22);
        checks++; if (state !== 2'd0 || ev_valid !== 1'b0) begin errors++; $display("FAIL sx_orphan got=%0d/%b exp=0/0", state, ev_valid); end
        send(8'hE2); send(8'h00); send(8'h40);
        exp_ev = {1'b1, 3'd6, 4'd2, 7'h00, 7'h40};
        checks++; if (ev !== exp_ev) begin errors++; $display("FAIL pitch got=%h exp=%h", ev, exp_ev); end
    endtask

    task automatic test_abort();
        send(8'h90); send(8'h3C); send(8'hB2);
        checks++; if (state !== 2'd1 || ev_valid !== 1'b0) begin errors++; $display("FAIL abort_d2 got=%0d/%b exp=1/0", state, ev_valid); end
        send(8'h05); send(8'h06);
        exp_ev = {1'b1, 3'd3, 4'd2, 7'h05, 7'h06};
        checks++; if (ev !== exp_ev) begin errors++; $display("FAIL abort_cc got=%h exp=%h", ev, exp_ev); end
    endtask

    task automatic test_reset_byte();
        send(8'h90); send(8'h3C); send(8'hFF);
        checks++; if (sys_reset !== 1'b1 || ev_valid !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL ff_pulse got=%b/%b/%0d exp=1/0/0", sys_reset, ev_valid, state); end
        send(8'h50);
        checks++; if (sys_reset !== 1'b0 || ev_valid !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL ff_after got=%b/%b/%0d exp=0/0/0", sys_reset, ev_valid, state); end
    endtask

    task automatic test_rst_mid();
        send(8'hB1); send(8'h01);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        checks++; if (ev !== 22'd0 || state !== 2'd0) begin errors++; $display("FAIL rst_mid got=%h/%0d exp=0/0", ev, state); end
        send(8'h02);
        checks++; if (ev !== 22'd0 || state !== 2'd0 || sys_reset !== 1'b0) begin errors++; $display("FAIL rst_after got=%h/%0d exp=0/0", ev, state); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_running_status();
        test_back_to_back();
        test_filter();
        test_sysex();
        test_abort();
        test_reset_byte();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
